sum_uart_tx: RTL and testbench

- Downstream consumer of the 8-bit adder result (the uo_out sum) in the tile.
- Accepts bytes over a valid/ready handshake into a 1-entry holding register.
- Serialises each byte as an 8N1 UART frame on a single pin, LSB first.
- Lets the tile stream sums off-chip over one uo_out/uio_out bit.

---
 rtl/sum_uart_pkg.sv | 16 +
 rtl/sum_uart_baud_cnt.sv | 28 ++
 rtl/sum_uart_tx.sv | 151 +++++++++++++++
 tb/tb_sum_uart_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum_uart_tx UART transmitter.
package sum_uart_pkg;

    localparam int DATA_W         = 8;
    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sum_uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, bit_tick marks the last cycle.
module sum_uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    logic [CNT_W-1:0] r_cnt;

    assign bit_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= bit_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// Byte-to-UART serialiser with a 1-entry holding register (8N1, LSB first).
// Define SUM_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    uart_state_e       r_state, w_state_next;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [2:0]        r_bit_idx, w_bit_idx_next;
    logic              r_tx, w_tx_next;
    logic              w_load;
    logic              w_accept;
    logic              w_bit_tick;
`ifdef SUM_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    assign w_accept = in_valid && !r_hold_valid;
    assign in_ready = !r_hold_valid;
    assign tx       = r_tx;
    assign busy     = (r_state != IDLE) || r_hold_valid;

    sum_uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_load),
        .en       (r_state != IDLE),
        .bit_tick (w_bit_tick)
    );

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_load         = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_hold_valid) begin
                    w_load       = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_tick) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef SUM_UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef SUM_UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_tick) w_state_next = STOP;
            end
`endif
            STOP: begin
                // A queued byte chains straight into the next start bit.
                if (w_bit_tick) begin
                    if (r_hold_valid) begin
                        w_load       = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_load) begin
            w_shift_next   = r_hold_data;
            w_bit_idx_next = 3'd0;
        end

        // tx is driven from the next state so the line is a clean flop output.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef SUM_UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_data  <= in_data;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

`ifdef SUM_UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^r_hold_data;
        end
    end
`endif

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed self-checking bench for sum_uart_tx at CLKS_PER_BIT=4.
module tb_sum_uart_tx;

    localparam int CPB = 4;
`ifdef SUM_UART_TX_PARITY_EN
    localparam int FRAME_BITS = sum_uart_pkg::FRAME_BITS_8E1;
`else
    localparam int FRAME_BITS = sum_uart_pkg::FRAME_BITS_8N1;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int n_checks;
    int n_fail;
    bit q_exp[$];

    sum_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line levels for one frame, one entry per clock cycle.
    task automatic push_frame(input logic [7:0] b, input bit par);
        for (int j = 0; j < CPB; j++) q_exp.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < CPB; j++) q_exp.push_back(b[i]);
`ifdef SUM_UART_TX_PARITY_EN
        for (int j = 0; j < CPB; j++) q_exp.push_back(par);
`endif
        for (int j = 0; j < CPB; j++) q_exp.push_back(1'b1);
    endtask

    // Samples tx once per cycle, starting with the cycle after the accept edge.
    task automatic check_seq(input string name);
        int idx = 0;
        while (q_exp.size() > 0) begin
            bit e = q_exp.pop_front();
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (tx !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: tx=%b expected %b", name, idx + 1, tx, e);
            end
            idx++;
        end
    endtask

    // Returns #1 after the accept edge.
    task automatic send(input logic [7:0] b, input string name);
        int waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL %s accept timeout: in_ready=%b expected 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_idle_next(input string name);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: busy=%b in_ready=%b tx=%b expected 0 1 1",
                     name, busy, in_ready, tx);
        end
    endtask

    task automatic test_reset();
        bit bad = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: tx=%b in_ready=%b busy=%b expected 1 1 0",
                     tx, in_ready, busy);
        end
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_idle_line: tx left 1 during 20 idle cycles, expected steady 1");
        end
    endtask

    task automatic test_single_byte();
        push_frame(8'hA5, 1'b0);
        send(8'hA5, "single");
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after_accept: in_ready=%b busy=%b expected 0 1", in_ready, busy);
        end
        check_seq("single_a5");
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_last_stop_cycle: busy=%b expected 1", busy);
        end
        expect_idle_next("single_end");
    endtask

    task automatic test_back_to_back();
        push_frame(8'h00, 1'b0);
        push_frame(8'hFF, 1'b0);
        send(8'h00, "b2b_first");
        fork
            check_seq("b2b_00_ff");
            begin
                send(8'hFF, "b2b_second");
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_after_second: in_ready=%b expected 0", in_ready);
                end
            end
        join
        expect_idle_next("b2b_end");
    endtask

    task automatic test_backpressure();
        push_frame(8'h11, 1'b0);
        push_frame(8'h22, 1'b0);
        push_frame(8'h99, 1'b0);
        send(8'h11, "bp_first");
        fork
            check_seq("bp_11_22_99");
            begin
                int waited = 0;
                send(8'h22, "bp_second");
                @(negedge clk);
                in_data  = 8'h3C;
                in_valid = 1'b1;
                repeat (10) @(negedge clk);
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stalled: in_ready=%b expected 0", in_ready);
                end
                in_data = 8'h99;
                while (!in_ready && waited < 200) begin
                    @(negedge clk);
                    waited++;
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = 8'h55;
            end
        join
        expect_idle_next("bp_end");
    endtask

    task automatic test_reset_mid_frame();
        bit bad = 0;
        send(8'h5A, "rst_mid");
        repeat (18) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_bit3: busy=%b tx=%b expected 1 1", busy, tx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: tx=%b in_ready=%b busy=%b expected 1 1 0",
                     tx, in_ready, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_mid_residual: line activity after reset, expected idle");
        end
    endtask

`ifdef SUM_UART_TX_PARITY_EN
    task automatic test_parity();
        push_frame(8'h07, 1'b1);
        send(8'h07, "par_07");
        check_seq("par_07");
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL par_07_len: busy=%b expected 1 on cycle %0d", busy, 11 * CPB);
        end
        expect_idle_next("par_07_end");
        push_frame(8'hA5, 1'b0);
        send(8'hA5, "par_a5");
        check_seq("par_a5");
        expect_idle_next("par_a5_end");
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
`ifdef SUM_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
